// File: rtl/vga_pkg.sv
// Shared types and geometry for the VGA framebuffer blocks.
// The display read-address generator uses the same cell geometry.
package vga_pkg;

  localparam int FB_COLS      = 100;
  localparam int FB_ROWS      = 75;
  localparam int FB_BYTES_DEF = FB_COLS * FB_ROWS;
  localparam int FB_BASE_DEF  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WR_LO,
    ST_WR_HI,
    ST_FIN
  } ld_state_e;

endpackage

// File: rtl/vga_fb_loader_arb_if.sv
// Bundle of control, CPU, memory and BRAM port A signals.
// The slave side is the loader; the master side is its surroundings.
interface vga_fb_loader_arb_if #(
  parameter int FB_AW  = 19,
  parameter int MEM_AW = 23
);

  logic              start;
  logic [MEM_AW-1:0] src_base;
  logic              busy;
  logic              done;

  logic              cpu_we;
  logic [FB_AW-1:0]  cpu_addr;
  logic [7:0]        cpu_data;

  logic              mem_re;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_valid;

  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [7:0]        fb_din;

  modport master (
    output start, src_base,
    output cpu_we, cpu_addr, cpu_data,
    output mem_data, mem_valid,
    input  busy, done,
    input  mem_re, mem_addr,
    input  fb_we, fb_addr, fb_din
  );

  modport slave (
    input  start, src_base,
    input  cpu_we, cpu_addr, cpu_data,
    input  mem_data, mem_valid,
    output busy, done,
    output mem_re, mem_addr,
    output fb_we, fb_addr, fb_din
  );

endinterface

// File: rtl/vga_fb_loader_arb_fb_port_mux.sv
// Registered 2:1 priority mux for BRAM port A.
// The CPU always wins; the copy side learns of it through o_copy_grant.
module fb_port_mux #(
  parameter int FB_AW = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cpu_we,
  input  logic [FB_AW-1:0] i_cpu_addr,
  input  logic [7:0]       i_cpu_data,
  input  logic             i_copy_req,
  input  logic [FB_AW-1:0] i_copy_addr,
  input  logic [7:0]       i_copy_data,
  output logic             o_copy_grant,
  output logic             o_fb_we,
  output logic [FB_AW-1:0] o_fb_addr,
  output logic [7:0]       o_fb_din
);

  logic             r_we;
  logic [FB_AW-1:0] r_addr;
  logic [7:0]       r_din;

  assign o_copy_grant = i_copy_req & ~i_cpu_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (i_cpu_we) begin
      r_we   <= 1'b1;
      r_addr <= i_cpu_addr;
      r_din  <= i_cpu_data;
    end else if (i_copy_req) begin
      r_we   <= 1'b1;
      r_addr <= i_copy_addr;
      r_din  <= i_copy_data;
    end else begin
      // idle port is driven to zero, not left holding the last write
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end
  end

  assign o_fb_we   = r_we;
  assign o_fb_addr = r_addr;
  assign o_fb_din  = r_din;

endmodule

// File: rtl/vga_fb_loader_arb.sv
// Framebuffer port A owner: CPU byte writes plus a block-copy engine
// that fetches 16-bit words and stores them as two bytes each.
module vga_fb_loader_arb
  import vga_pkg::*;
#(
  parameter int FB_AW    = 19,
  parameter int MEM_AW   = 23,
  parameter int FB_BYTES = FB_BYTES_DEF,
  parameter int FB_BASE  = FB_BASE_DEF
) (
  input logic clk,
  input logic rst,
  vga_fb_loader_arb_if.slave bus
);

  localparam int CW = $clog2(FB_BYTES + 1);

  ld_state_e         r_state;
  logic [CW-1:0]     r_cnt;
  logic [MEM_AW-1:0] r_src;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [15:0]       r_hold;
  logic              r_mem_re;
  logic              r_busy;
  logic              r_done;

  logic              w_copy_req;
  logic              w_grant;
  logic              w_last;
  logic [CW-1:0]     w_cnt_nxt;
  logic [FB_AW-1:0]  w_copy_addr;
  logic [7:0]        w_copy_data;

  assign w_copy_req  = (r_state == ST_WR_LO) ||
                       (r_state == ST_WR_HI);
  assign w_copy_addr = FB_AW'(FB_BASE) + FB_AW'(r_cnt);
  assign w_copy_data = (r_state == ST_WR_HI) ?
                       r_hold[15:8] : r_hold[7:0];
  assign w_cnt_nxt   = r_cnt + CW'(1);
  assign w_last      = (w_cnt_nxt == CW'(FB_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_src      <= '0;
      r_mem_addr <= '0;
      r_hold     <= '0;
      r_mem_re   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_src      <= bus.src_base;
            r_cnt      <= '0;
            r_mem_addr <= bus.src_base;
            r_mem_re   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_valid) begin
            r_hold   <= bus.mem_data;
            r_mem_re <= 1'b0;
            r_state  <= ST_WR_LO;
          end
        end
        ST_WR_LO: begin
          if (w_grant) begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_last ? ST_FIN : ST_WR_HI;
          end
        end
        ST_WR_HI: begin
          if (w_grant) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_state <= ST_FIN;
            end else begin
              // source advances by the byte count, two per word
              r_mem_addr <= r_src + MEM_AW'(w_cnt_nxt);
              r_mem_re   <= 1'b1;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_re   = r_mem_re;
  assign bus.mem_addr = r_mem_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

  fb_port_mux #(.FB_AW(FB_AW)) u_mux (
    .clk          (clk),
    .rst          (rst),
    .i_cpu_we     (bus.cpu_we),
    .i_cpu_addr   (bus.cpu_addr),
    .i_cpu_data   (bus.cpu_data),
    .i_copy_req   (w_copy_req),
    .i_copy_addr  (w_copy_addr),
    .i_copy_data  (w_copy_data),
    .o_copy_grant (w_grant),
    .o_fb_we      (bus.fb_we),
    .o_fb_addr    (bus.fb_addr),
    .o_fb_din     (bus.fb_din)
  );

endmodule

// File: tb/tb_vga_fb_loader_arb.sv
// Directed bench for the framebuffer loader: CPU vectors from a table,
// then hand-written copy, collision, odd-length and reset sequences.
module tb_vga_fb_loader_arb;

  localparam int FB_AW  = 19;
  localparam int MEM_AW = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_fb_loader_arb_if #(.FB_AW(FB_AW), .MEM_AW(MEM_AW)) b4 ();
  vga_fb_loader_arb_if #(.FB_AW(FB_AW), .MEM_AW(MEM_AW)) b3 ();

  vga_fb_loader_arb #(
    .FB_AW(FB_AW), .MEM_AW(MEM_AW), .FB_BYTES(4), .FB_BASE(1)
  ) u4 (.clk(clk), .rst(rst), .bus(b4));

  vga_fb_loader_arb #(
    .FB_AW(FB_AW), .MEM_AW(MEM_AW), .FB_BYTES(3), .FB_BASE(1)
  ) u3 (.clk(clk), .rst(rst), .bus(b3));

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // observed port A writes {addr,din}, read requests and done pulses
  logic [26:0] fq4[$];
  logic [26:0] fq3[$];
  logic [22:0] mq4[$];
  logic [22:0] mq3[$];
  int done4 = 0;
  int done3 = 0;
  int dcyc4 = 0;
  int lwcyc4 = 0;

  always @(negedge clk) begin
    if (b4.fb_we) begin
      fq4.push_back({b4.fb_addr, b4.fb_din});
      lwcyc4 <= cyc;
    end
    if (b4.done) begin
      done4 <= done4 + 1;
      dcyc4 <= cyc;
    end
    if (b3.fb_we) fq3.push_back({b3.fb_addr, b3.fb_din});
    if (b3.done) done3 <= done3 + 1;
  end

  function automatic logic [15:0] mem_word(input logic [22:0] a);
    case (a)
      23'h100: return 16'h1234;
      23'h102: return 16'hABCD;
      23'h200: return 16'h5678;
      23'h202: return 16'h9ABC;
      default: return 16'hDEAD;
    endcase
  endfunction

  // memory model for u4: auto responder or manual drive
  logic        auto4;
  logic        av4, mv4;
  logic [15:0] ad4, md4;
  assign b4.mem_valid = auto4 ? av4 : mv4;
  assign b4.mem_data  = auto4 ? ad4 : md4;

  initial begin
    av4 = 1'b0;
    ad4 = '0;
    forever begin
      @(negedge clk);
      if (auto4 && b4.mem_re) begin
        mq4.push_back(b4.mem_addr);
        repeat (2) @(negedge clk);
        ad4 = mem_word(b4.mem_addr);
        av4 = 1'b1;
        @(negedge clk);
        av4 = 1'b0;
      end
    end
  end

  initial begin
    b3.mem_valid = 1'b0;
    b3.mem_data  = '0;
    forever begin
      @(negedge clk);
      if (b3.mem_re) begin
        mq3.push_back(b3.mem_addr);
        repeat (2) @(negedge clk);
        b3.mem_data  = mem_word(b3.mem_addr);
        b3.mem_valid = 1'b1;
        @(negedge clk);
        b3.mem_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        ewe;
    logic [18:0] eaddr;
    logic [7:0]  edin;
  } vec_t;

  vec_t        tv[6];
  logic [26:0] ef4[4];
  logic [26:0] ef3[3];
  logic [22:0] em4[2];
  logic [22:0] em3[2];
  logic [63:0] act;
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int s_f, s_m, s_d;
    tv[0] = '{1'b1, 19'h10, 8'hA5, 1'b1, 19'h10, 8'hA5};
    tv[1] = '{1'b0, 19'h10, 8'hA5, 1'b0, 19'h0, 8'h0};
    tv[2] = '{1'b1, 19'h7FFFF, 8'hFF, 1'b1, 19'h7FFFF, 8'hFF};
    tv[3] = '{1'b1, 19'h0, 8'h3C, 1'b1, 19'h0, 8'h3C};
    tv[4] = '{1'b1, 19'h12C3, 8'h01, 1'b1, 19'h12C3, 8'h01};
    tv[5] = '{1'b0, 19'h55, 8'h66, 1'b0, 19'h0, 8'h0};
    ef4 = '{{19'd1, 8'h34}, {19'd2, 8'h12},
            {19'd3, 8'hCD}, {19'd4, 8'hAB}};
    ef3 = '{{19'd1, 8'h78}, {19'd2, 8'h56}, {19'd3, 8'hBC}};
    em4 = '{23'h100, 23'h102};
    em3 = '{23'h200, 23'h202};

    rst = 1'b1;
    auto4 = 1'b0;
    mv4 = 1'b0;
    md4 = '0;
    b4.start = 1'b0; b4.src_base = '0;
    b4.cpu_we = 1'b0; b4.cpu_addr = '0; b4.cpu_data = '0;
    b3.start = 1'b0; b3.src_base = '0;
    b3.cpu_we = 1'b0; b3.cpu_addr = '0; b3.cpu_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset", {b4.fb_we, b4.fb_addr, b4.fb_din, b4.mem_re,
                  b4.mem_addr, b4.busy, b4.done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // CPU-only table
    foreach (tv[i]) begin
      @(negedge clk);
      b4.cpu_we   = tv[i].we;
      b4.cpu_addr = tv[i].addr;
      b4.cpu_data = tv[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("cpu_vec%0d", i),
          {b4.fb_we, b4.fb_addr, b4.fb_din},
          {tv[i].ewe, tv[i].eaddr, tv[i].edin});
    end
    @(negedge clk);
    b4.cpu_we = 1'b0;

    // full copy, FB_BYTES=4, 3-cycle memory latency
    s_f = fq4.size(); s_m = mq4.size(); s_d = done4;
    auto4 = 1'b1;
    @(negedge clk);
    b4.start = 1'b1;
    b4.src_base = 23'h100;
    @(posedge clk);
    #1;
    chk("copy_start", {b4.busy, b4.mem_re, b4.mem_addr},
        {1'b1, 1'b1, 23'h100});
    @(negedge clk);
    b4.start = 1'b0;
    for (int k = 0; k < 100 && done4 == s_d; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("copy_done_cnt", 64'(done4 - s_d), 64'd1);
    chk("copy_done_time", 64'(dcyc4 - lwcyc4), 64'd1);
    chk("copy_nwr", 64'(fq4.size() - s_f), 64'd4);
    for (int i = 0; i < 4; i++) begin
      act = (s_f + i < fq4.size()) ? 64'(fq4[s_f + i]) : NONE;
      chk($sformatf("copy_wr%0d", i), act, 64'(ef4[i]));
    end
    chk("copy_nreq", 64'(mq4.size() - s_m), 64'd2);
    for (int i = 0; i < 2; i++) begin
      act = (s_m + i < mq4.size()) ? 64'(mq4[s_m + i]) : NONE;
      chk($sformatf("copy_maddr%0d", i), act, 64'(em4[i]));
    end
    chk("copy_idle", {b4.busy, b4.mem_re}, 64'h0);
    auto4 = 1'b0;

    // start together with a CPU write, then collision in WR_LO
    s_d = done4;
    @(negedge clk);
    b4.start = 1'b1; b4.src_base = 23'h100;
    b4.cpu_we = 1'b1; b4.cpu_addr = 19'h40; b4.cpu_data = 8'h99;
    @(posedge clk);
    #1;
    chk("sim_cpu", {b4.fb_we, b4.fb_addr, b4.fb_din},
        {1'b1, 19'h40, 8'h99});
    chk("sim_req", {b4.busy, b4.mem_re, b4.mem_addr},
        {1'b1, 1'b1, 23'h100});
    @(negedge clk);
    b4.start = 1'b0; b4.cpu_we = 1'b0;
    mv4 = 1'b1; md4 = 16'h1234;
    @(posedge clk);
    #1;
    chk("req_drop", {b4.mem_re, b4.fb_we}, 64'h0);
    @(negedge clk);
    mv4 = 1'b0;
    b4.cpu_we = 1'b1; b4.cpu_addr = 19'h20; b4.cpu_data = 8'h11;
    @(posedge clk);
    #1;
    chk("coll_cpu1", {b4.fb_we, b4.fb_addr, b4.fb_din},
        {1'b1, 19'h20, 8'h11});
    @(negedge clk);
    b4.cpu_addr = 19'h21; b4.cpu_data = 8'h22;
    @(posedge clk);
    #1;
    chk("coll_cpu2", {b4.fb_we, b4.fb_addr, b4.fb_din},
        {1'b1, 19'h21, 8'h22});
    @(negedge clk);
    b4.cpu_we = 1'b0;
    @(posedge clk);
    #1;
    chk("coll_lo", {b4.fb_we, b4.fb_addr, b4.fb_din},
        {1'b1, 19'd1, 8'h34});
    @(posedge clk);
    #1;
    chk("coll_hi", {b4.fb_we, b4.fb_addr, b4.fb_din},
        {1'b1, 19'd2, 8'h12});
    chk("coll_req2", {b4.mem_re, b4.mem_addr}, {1'b1, 23'h102});
    @(negedge clk);
    mv4 = 1'b1; md4 = 16'hABCD;
    @(negedge clk);
    mv4 = 1'b0;
    for (int k = 0; k < 50 && done4 == s_d; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("coll_done", 64'(done4 - s_d), 64'd1);

    // second start ignored, then reset mid-REQ
    s_d = done4;
    @(negedge clk);
    b4.start = 1'b1; b4.src_base = 23'h100;
    @(posedge clk);
    #1;
    chk("busy_start", {b4.busy, b4.mem_addr}, {1'b1, 23'h100});
    @(negedge clk);
    b4.src_base = 23'h300;
    @(posedge clk);
    #1;
    chk("restart_ign", {b4.busy, b4.mem_re, b4.mem_addr},
        {1'b1, 1'b1, 23'h100});
    @(negedge clk);
    b4.start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abort", {b4.mem_re, b4.busy, b4.fb_we, b4.done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(done4 - s_d), 64'd0);

    // odd length on u3
    s_f = fq3.size(); s_m = mq3.size(); s_d = done3;
    @(negedge clk);
    b3.start = 1'b1; b3.src_base = 23'h200;
    @(negedge clk);
    b3.start = 1'b0;
    for (int k = 0; k < 100 && done3 == s_d; k++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    chk("odd_done", 64'(done3 - s_d), 64'd1);
    chk("odd_nwr", 64'(fq3.size() - s_f), 64'd3);
    for (int i = 0; i < 3; i++) begin
      act = (s_f + i < fq3.size()) ? 64'(fq3[s_f + i]) : NONE;
      chk($sformatf("odd_wr%0d", i), act, 64'(ef3[i]));
    end
    for (int i = 0; i < 2; i++) begin
      act = (s_m + i < mq3.size()) ? 64'(mq3[s_m + i]) : NONE;
      chk($sformatf("odd_maddr%0d", i), act, 64'(em3[i]));
    end
    chk("odd_idle", {b3.busy, b3.mem_re}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
